user_rc_tag_tracker: RTL and testbench

- Tracks outstanding non-posted (read) requests between the TLP encoder's issue point and the requester-completion stream.
- Allocates and guards tag usage, and subtracts completion dword counts per tag.
- Reports per-tag termination (ok / error / length mismatch / timeout) and flags unexpected completions.
- Monitors the RC stream passively at the output of the completion queue and never backpressures it.

---
 rtl/user_rc_tag_tracker_pkg.sv | 35 +++
 rtl/user_tag_age_scan.sv | 66 ++++++
 rtl/user_rc_tag_tracker.sv | 185 ++++++++++++++++++
 tb/tb_user_rc_tag_tracker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/user_rc_tag_tracker_pkg.sv
// Shared constants for the RC tag tracker: descriptor field positions,
// termination status encodings and entry field widths.
package user_rc_tag_tracker_pkg;

  localparam int TAG_W = 8;
  localparam int DW_W  = 11;
  localparam int AGE_W = 4;
  localparam int CNT_W = 9;

  localparam int RC_ERR_LSB       = 12;
  localparam int RC_ERR_MSB       = 15;
  localparam int RC_REQ_DONE_BIT  = 30;
  localparam int RC_DWCNT_LSB     = 32;
  localparam int RC_DWCNT_MSB     = 42;
  localparam int RC_STAT_LSB      = 43;
  localparam int RC_STAT_MSB      = 45;
  localparam int RC_TAG_LSB       = 64;
  localparam int RC_TAG_MSB       = 71;

  typedef enum logic [1:0] {
    DONE_OK      = 2'd0,
    DONE_CPL_ERR = 2'd1,
    DONE_LEN_ERR = 2'd2,
    DONE_TIMEOUT = 2'd3
  } done_status_e;

  typedef struct packed {
    logic [3:0]       err_code;
    logic             req_completed;
    logic [DW_W-1:0]  dw_cnt;
    logic [2:0]       cpl_status;
    logic [TAG_W-1:0] tag;
  } rc_desc_t;

endpackage

// File: rtl/user_tag_age_scan.sv
// Per-tag age counters driven by a shared tick prescaler, plus the
// lowest-index select over entries that have reached the timeout age.
module user_tag_age_scan
  import user_rc_tag_tracker_pkg::*;
#(
  parameter int NUM_TAGS      = 32,
  parameter int TICK_CYCLES   = 1024,
  parameter int TIMEOUT_TICKS = 15,
  parameter int IDX_W         = $clog2(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_TAGS-1:0] valid_i,
  input  logic                alloc_vld,
  input  logic [IDX_W-1:0]    alloc_idx,
  output logic                to_found,
  output logic [IDX_W-1:0]    to_idx
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [AGE_W-1:0] age_q [NUM_TAGS];
  logic [AGE_W-1:0] age_d [NUM_TAGS];
  logic [NUM_TAGS-1:0] timed_out;

  always_comb begin
    tick    = (presc_q == PW'(TICK_CYCLES - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // A fresh allocation restarts the age even if a tick lands on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      age_d[i] = age_q[i];
      if (alloc_vld && (alloc_idx == IDX_W'(i))) begin
        age_d[i] = '0;
      end else if (tick && valid_i[i] && (age_q[i] < AGE_W'(TIMEOUT_TICKS))) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    to_idx = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      timed_out[i] = valid_i[i] && (age_q[i] == AGE_W'(TIMEOUT_TICKS));
    end
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (timed_out[i]) to_idx = IDX_W'(i);
    end
    to_found = |timed_out;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // Ages are only meaningful while the entry is valid, so they carry no reset.
  always_ff @(posedge clk) begin
    age_q <= age_d;
  end

endmodule

// File: rtl/user_rc_tag_tracker.sv
// Tracks outstanding read tags from issue to completion, subtracting
// completion DW counts and reporting per-tag termination or timeout.
module user_rc_tag_tracker
  import user_rc_tag_tracker_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 128,
  parameter int NUM_TAGS      = 32,
  parameter int TICK_CYCLES   = 1024,
  parameter int TIMEOUT_TICKS = 15
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic                    user_lnk_up,
  input  logic                    iss_valid,
  output logic                    iss_ready,
  input  logic [7:0]              iss_tag,
  input  logic [10:0]             iss_dw,
  input  logic [C_DATA_WIDTH-1:0] rc_tdata,
  input  logic                    rc_tvalid,
  input  logic                    rc_tlast,
  output logic                    done_valid,
  output logic [7:0]              done_tag,
  output logic [1:0]              done_status,
  output logic                    unexp_cpl,
  output logic [8:0]              outstanding
);

  localparam int IDX_W = $clog2(NUM_TAGS);

  logic                flush;
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [DW_W-1:0]     rem_q [NUM_TAGS];
  logic [DW_W-1:0]     rem_d [NUM_TAGS];
  logic                sop_q, sop_d;
  logic                done_valid_q, done_valid_d;
  logic [TAG_W-1:0]    done_tag_q, done_tag_d;
  done_status_e        done_status_q, done_status_d;
  logic                unexp_q, unexp_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;

  logic [IDX_W-1:0]    iss_idx;
  logic                iss_fire;
  rc_desc_t            desc;
  logic                desc_beat;
  logic [IDX_W-1:0]    d_idx;
  logic                d_hit;
  logic [DW_W-1:0]     rem_cur, rem_new;
  logic                cpl_rep;
  done_status_e        cpl_st;
  logic                to_found;
  logic [IDX_W-1:0]    to_idx;
  logic                unused_bits;

  assign flush = reset || !user_lnk_up;

  assign unused_bits = ^{rc_tdata[C_DATA_WIDTH-1:RC_TAG_MSB+1],
                         rc_tdata[RC_TAG_LSB-1:RC_STAT_MSB+1],
                         rc_tdata[RC_DWCNT_LSB-1:RC_REQ_DONE_BIT+1],
                         rc_tdata[RC_REQ_DONE_BIT-1:RC_ERR_MSB+1],
                         rc_tdata[RC_ERR_LSB-1:0]};

  always_comb begin
    iss_idx   = iss_tag[IDX_W-1:0];
    iss_ready = user_lnk_up && (int'(iss_tag) < NUM_TAGS) && !valid_q[iss_idx];
    iss_fire  = iss_valid && iss_ready;
  end

  always_comb begin
    desc.err_code      = rc_tdata[RC_ERR_MSB:RC_ERR_LSB];
    desc.req_completed = rc_tdata[RC_REQ_DONE_BIT];
    desc.dw_cnt        = rc_tdata[RC_DWCNT_MSB:RC_DWCNT_LSB];
    desc.cpl_status    = rc_tdata[RC_STAT_MSB:RC_STAT_LSB];
    desc.tag           = rc_tdata[RC_TAG_MSB:RC_TAG_LSB];
    desc_beat          = rc_tvalid && sop_q;
    d_idx              = desc.tag[IDX_W-1:0];
    d_hit              = (int'(desc.tag) < NUM_TAGS) && valid_q[d_idx];
    rem_cur            = rem_q[d_idx];
    rem_new            = rem_cur - desc.dw_cnt;
  end

  user_tag_age_scan #(
    .NUM_TAGS      (NUM_TAGS),
    .TICK_CYCLES   (TICK_CYCLES),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .IDX_W         (IDX_W)
  ) u_age_scan (
    .clk       (user_clk),
    .rst       (flush),
    .valid_i   (valid_q),
    .alloc_vld (iss_fire),
    .alloc_idx (iss_idx),
    .to_found  (to_found),
    .to_idx    (to_idx)
  );

  // Completion decode, then timeout fallback, then issue: the issued tag is
  // never one being freed because iss_ready only accepts invalid entries.
  always_comb begin
    valid_d       = valid_q;
    rem_d         = rem_q;
    sop_d         = sop_q;
    done_valid_d  = 1'b0;
    done_tag_d    = done_tag_q;
    done_status_d = done_status_q;
    unexp_d       = 1'b0;
    cpl_rep       = 1'b0;
    cpl_st        = DONE_OK;

    if (rc_tvalid) sop_d = rc_tlast;

    if (desc_beat) begin
      if (!d_hit) begin
        unexp_d = 1'b1;
      end else if ((desc.err_code != '0) || (desc.cpl_status != '0)) begin
        valid_d[d_idx] = 1'b0;
        cpl_rep        = 1'b1;
        cpl_st         = DONE_CPL_ERR;
      end else if (desc.dw_cnt > rem_cur) begin
        valid_d[d_idx] = 1'b0;
        cpl_rep        = 1'b1;
        cpl_st         = DONE_LEN_ERR;
      end else if (desc.req_completed) begin
        valid_d[d_idx] = 1'b0;
        cpl_rep        = 1'b1;
        cpl_st         = (rem_new == '0) ? DONE_OK : DONE_LEN_ERR;
      end else begin
        rem_d[d_idx] = rem_new;
      end
    end

    if (cpl_rep) begin
      done_valid_d  = 1'b1;
      done_tag_d    = desc.tag;
      done_status_d = cpl_st;
    end else if (to_found) begin
      valid_d[to_idx] = 1'b0;
      done_valid_d    = 1'b1;
      done_tag_d      = TAG_W'(to_idx);
      done_status_d   = DONE_TIMEOUT;
    end

    if (iss_fire) begin
      valid_d[iss_idx] = 1'b1;
      rem_d[iss_idx]   = (iss_dw == '0) ? DW_W'(1024) : iss_dw;
    end
  end

  always_comb begin
    outstanding_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      outstanding_d = outstanding_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge user_clk) begin
    if (flush) begin
      valid_q       <= '0;
      sop_q         <= 1'b1;
      done_valid_q  <= 1'b0;
      done_tag_q    <= '0;
      done_status_q <= DONE_OK;
      unexp_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      valid_q       <= valid_d;
      sop_q         <= sop_d;
      done_valid_q  <= done_valid_d;
      done_tag_q    <= done_tag_d;
      done_status_q <= done_status_d;
      unexp_q       <= unexp_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge user_clk) begin
    rem_q <= rem_d;
  end

  assign done_valid  = done_valid_q;
  assign done_tag    = done_tag_q;
  assign done_status = done_status_q;
  assign unexp_cpl   = unexp_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_user_rc_tag_tracker.sv
// Directed bench for the RC tag tracker: one instance with default ageing,
// one with a fast tick to exercise timeouts; both share the stimulus.
module tb_user_rc_tag_tracker;

  logic         clk = 1'b0;
  logic         reset;
  logic         user_lnk_up;
  logic         iss_valid;
  logic [7:0]   iss_tag;
  logic [10:0]  iss_dw;
  logic [127:0] rc_tdata;
  logic         rc_tvalid;
  logic         rc_tlast;

  logic         iss_ready, done_valid, unexp_cpl;
  logic [7:0]   done_tag;
  logic [1:0]   done_status;
  logic [8:0]   outstanding;

  logic         to_iss_ready, to_done_valid, to_unexp;
  logic [7:0]   to_done_tag;
  logic [1:0]   to_done_status;
  logic [8:0]   to_outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_rc_tag_tracker #(
    .C_DATA_WIDTH(128), .NUM_TAGS(32), .TICK_CYCLES(1024), .TIMEOUT_TICKS(15)
  ) dut (
    .user_clk(clk), .reset(reset), .user_lnk_up(user_lnk_up),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag), .iss_dw(iss_dw),
    .rc_tdata(rc_tdata), .rc_tvalid(rc_tvalid), .rc_tlast(rc_tlast),
    .done_valid(done_valid), .done_tag(done_tag), .done_status(done_status),
    .unexp_cpl(unexp_cpl), .outstanding(outstanding)
  );

  user_rc_tag_tracker #(
    .C_DATA_WIDTH(128), .NUM_TAGS(32), .TICK_CYCLES(4), .TIMEOUT_TICKS(2)
  ) dut_to (
    .user_clk(clk), .reset(reset), .user_lnk_up(user_lnk_up),
    .iss_valid(iss_valid), .iss_ready(to_iss_ready), .iss_tag(iss_tag), .iss_dw(iss_dw),
    .rc_tdata(rc_tdata), .rc_tvalid(rc_tvalid), .rc_tlast(rc_tlast),
    .done_valid(to_done_valid), .done_tag(to_done_tag), .done_status(to_done_status),
    .unexp_cpl(to_unexp), .outstanding(to_outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input int tag, input int dw);
    iss_valid = 1'b1;
    iss_tag   = tag[7:0];
    iss_dw    = dw[10:0];
    step();
    iss_valid = 1'b0;
  endtask

  function automatic logic [127:0] desc(input int tag, input int dw, input bit rc,
                                        input int err, input int st);
    logic [127:0] d;
    d          = '0;
    d[127:100] = 28'hABCDEF1;
    d[15:12]   = err[3:0];
    d[30]      = rc;
    d[42:32]   = dw[10:0];
    d[45:43]   = st[2:0];
    d[71:64]   = tag[7:0];
    return d;
  endfunction

  task automatic send(input logic [127:0] d, input bit last);
    rc_tdata  = d;
    rc_tvalid = 1'b1;
    rc_tlast  = last;
    step();
    rc_tvalid = 1'b0;
    rc_tlast  = 1'b0;
  endtask

  initial begin
    bit seen;
    reset       = 1'b1;
    user_lnk_up = 1'b1;
    iss_valid   = 1'b0;
    iss_tag     = '0;
    iss_dw      = '0;
    rc_tdata    = '0;
    rc_tvalid   = 1'b0;
    rc_tlast    = 1'b0;
    do_reset();

    chk("rst_outstanding", outstanding, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_done_status", done_status, 0);
    chk("rst_unexp", unexp_cpl, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_to_iss_ready", to_iss_ready, 1);

    // single completion
    issue(5, 16);
    chk("t5_outstanding_1", outstanding, 1);
    send(desc(5, 16, 1, 0, 0), 1);
    chk("t5_done_valid", done_valid, 1);
    chk("t5_done_tag", done_tag, 5);
    chk("t5_done_status", done_status, 0);
    chk("t5_outstanding_0", outstanding, 0);
    step();
    chk("t5_done_pulse", done_valid, 0);

    // 1024 DW split into four completions
    issue(3, 0);
    for (int k = 0; k < 3; k++) begin
      send(desc(3, 256, 0, 0, 0), 1);
      chk("t3_partial_no_done", done_valid, 0);
      chk("t3_partial_outstanding", outstanding, 1);
    end
    send(desc(3, 256, 1, 0, 0), 1);
    chk("t3_done_valid", done_valid, 1);
    chk("t3_done_tag", done_tag, 3);
    chk("t3_done_status", done_status, 0);
    chk("t3_outstanding", outstanding, 0);

    // unexpected completions and error terminations
    send(desc(9, 4, 1, 0, 0), 1);
    chk("t9_unexp", unexp_cpl, 1);
    chk("t9_no_done", done_valid, 0);
    chk("t9_outstanding", outstanding, 0);
    send(desc(40, 4, 1, 0, 0), 1);
    chk("t40_unexp", unexp_cpl, 1);
    issue(4, 8);
    send(desc(4, 8, 1, 0, 1), 1);
    chk("t4_unexp_clear", unexp_cpl, 0);
    chk("t4_cplerr_valid", done_valid, 1);
    chk("t4_cplerr_tag", done_tag, 4);
    chk("t4_cplerr_status", done_status, 1);
    chk("t4_outstanding", outstanding, 0);
    issue(12, 8);
    send(desc(12, 8, 1, 3, 0), 1);
    chk("t12_errcode_status", done_status, 1);
    issue(6, 4);
    send(desc(6, 8, 0, 0, 0), 1);
    chk("t6_overrun_valid", done_valid, 1);
    chk("t6_overrun_status", done_status, 2);
    chk("t6_overrun_outstanding", outstanding, 0);
    issue(10, 8);
    send(desc(10, 4, 1, 0, 0), 1);
    chk("t10_short_tag", done_tag, 10);
    chk("t10_short_status", done_status, 2);
    chk("t10_outstanding", outstanding, 0);

    // timeouts on the fast-ageing instance
    do_reset();
    issue(1, 4);
    issue(2, 4);
    chk("to_outstanding_2", to_outstanding, 2);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = to_done_valid;
    end
    chk("to_report_seen", seen, 1);
    chk("to_first_tag", to_done_tag, 1);
    chk("to_first_status", to_done_status, 3);
    step();
    chk("to_second_valid", to_done_valid, 1);
    chk("to_second_tag", to_done_tag, 2);
    chk("to_second_status", to_done_status, 3);
    chk("to_outstanding_0", to_outstanding, 0);
    chk("to_main_no_timeout", outstanding, 2);
    send(desc(1, 4, 1, 0, 0), 1);
    chk("to_late_unexp", to_unexp, 1);
    chk("to_late_main_done", done_valid, 1);
    chk("to_late_main_status", done_status, 0);

    // re-issue guard and simultaneous issue/free
    issue(7, 2);
    chk("t7_outstanding", outstanding, 2);
    iss_valid = 1'b1;
    iss_tag   = 8'd7;
    #1;
    chk("t7_reissue_blocked", iss_ready, 0);
    step();
    chk("t7_outstanding_same", outstanding, 2);
    iss_tag   = 8'd8;
    iss_dw    = 11'd4;
    rc_tdata  = desc(7, 2, 1, 0, 0);
    rc_tvalid = 1'b1;
    rc_tlast  = 1'b1;
    #1;
    chk("t8_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    rc_tvalid = 1'b0;
    rc_tlast  = 1'b0;
    chk("t78_done_tag", done_tag, 7);
    chk("t78_done_status", done_status, 0);
    chk("t78_outstanding", outstanding, 2);
    #1;
    chk("t8_now_busy", iss_ready, 0);

    // link-down flush
    do_reset();
    for (int t = 11; t < 15; t++) issue(t, 16);
    chk("lnk_outstanding_4", outstanding, 4);
    user_lnk_up = 1'b0;
    iss_tag     = 8'd20;
    #1;
    chk("lnk_down_not_ready", iss_ready, 0);
    step();
    chk("lnk_outstanding_0", outstanding, 0);
    chk("lnk_no_done", done_valid, 0);
    user_lnk_up = 1'b1;

    // SOP handling across a multi-beat packet and a mid-packet reset
    issue(2, 8);
    send(desc(2, 4, 0, 0, 0), 0);
    chk("sop_first_no_done", done_valid, 0);
    send(desc(25, 4, 1, 0, 0), 1);
    chk("sop_data_beat_ignored", unexp_cpl, 0);
    send(desc(2, 4, 1, 0, 0), 1);
    chk("sop_next_pkt_status", done_status, 0);
    chk("sop_next_pkt_valid", done_valid, 1);
    issue(2, 4);
    send(desc(2, 1, 0, 0, 0), 0);
    do_reset();
    chk("mid_rst_outstanding", outstanding, 0);
    issue(2, 4);
    send(desc(2, 4, 1, 0, 0), 1);
    chk("mid_rst_sop_valid", done_valid, 1);
    chk("mid_rst_sop_tag", done_tag, 2);
    chk("mid_rst_sop_status", done_status, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
